dispense_sequencer: RTL and testbench

Sequences one candy-dispense transaction from the Raspberry Pi request lines. It latches the amount code and drives the stepper for a fixed step count, then runs the DC motor for a fixed hold time. It then completes a four-phase req/ack handshake back to the Pi. It sits between the Pi GPIO inputs and the stepper/DC-motor output pins and replaces free-running combinational motor selection with counted, timed motion.

---
 rtl/dispense_pkg.sv | 34 +++
 rtl/dispense_tick_gen.sv | 51 +++++
 rtl/dispense_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_dispense_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dispense_pkg.sv
// Shared types and constants for the candy dispense sequencer.
package dispense_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        DC_RUN = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_e;

    localparam logic [1:0] AMT_SMALL   = 2'b00;
    localparam logic [1:0] AMT_MED     = 2'b01;
    localparam logic [1:0] AMT_LARGE   = 2'b10;
    localparam logic [1:0] AMT_INVALID = 2'b11;

    typedef struct packed {
        logic step;
        logic dir;
        logic dc_in1;
        logic dc_in2;
        logic dc_pwm;
    } motor_out_t;

    // Stepper parked, DC bridge braked.
    localparam motor_out_t MOTOR_BRAKE = '{
        step:   1'b0,
        dir:    1'b0,
        dc_in1: 1'b0,
        dc_in2: 1'b1,
        dc_pwm: 1'b0
    };

endpackage

// File: rtl/dispense_tick_gen.sv
// Step-tick divider and DC PWM counter for the dispense sequencer.
module dispense_tick_gen #(
    parameter int unsigned STEP_DIV   = 2000,
    parameter int unsigned PWM_PERIOD = 200,
    parameter int unsigned PWM_DUTY   = 80
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c,
    output logic o_pwm_c
);

    localparam int unsigned TICK_W = $clog2(STEP_DIV);
    localparam int unsigned PWM_W  = $clog2(PWM_PERIOD);

    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] w_tick_cnt_nxt;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [PWM_W-1:0]  w_pwm_cnt_inc;
    logic [PWM_W-1:0]  w_pwm_cnt_nxt;

    assign o_tick_c      = i_en && (r_tick_cnt == TICK_W'(STEP_DIV - 1));
    assign w_pwm_cnt_inc = (r_pwm_cnt == PWM_W'(PWM_PERIOD - 1)) ? '0 : r_pwm_cnt + PWM_W'(1);
    // PWM level for the next cycle, so the registered output lines up with the count.
    assign o_pwm_c       = (32'(w_pwm_cnt_inc) < PWM_DUTY);

    always_comb begin
        w_tick_cnt_nxt = r_tick_cnt;
        w_pwm_cnt_nxt  = r_pwm_cnt;
        if (i_clr) begin
            w_tick_cnt_nxt = '0;
            w_pwm_cnt_nxt  = '0;
        end else if (i_en) begin
            w_tick_cnt_nxt = o_tick_c ? '0 : r_tick_cnt + TICK_W'(1);
            w_pwm_cnt_nxt  = w_pwm_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tick_cnt <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_tick_cnt <= w_tick_cnt_nxt;
            r_pwm_cnt  <= w_pwm_cnt_nxt;
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// One candy-dispense transaction: counted stepper motion, timed DC run, req/ack handshake.
// Optional DISPENSE_ABORT_EN: a req drop during motion returns straight to IDLE.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int unsigned STEP_DIV    = 2000,
    parameter int unsigned PWM_PERIOD  = 200,
    parameter int unsigned PWM_DUTY    = 80,
    parameter int unsigned STEPS_SMALL = 200,
    parameter int unsigned STEPS_MED   = 400,
    parameter int unsigned STEPS_LARGE = 800,
    parameter int unsigned DC_HOLD     = 520
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_i,
    input  logic [1:0] amount_i,
    output logic       step_o,
    output logic       dir_o,
    output logic       dc_in1_o,
    output logic       dc_in2_o,
    output logic       dc_pwm_o,
    output logic       ack_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int unsigned CNT_W = 16;

    logic             r_req_s1;
    logic             r_req_s2;
    logic             r_req_d;
    logic [1:0]       r_amt_s1;
    logic [1:0]       r_amt_s2;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target;
    motor_out_t       r_out;
    logic             r_ack;
    logic             r_busy;
    logic             r_err;

    state_e           w_next_state;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_target_nxt;
    motor_out_t       w_out_nxt;
    logic             w_step_nxt;
    logic             w_ack_nxt;
    logic             w_busy_nxt;
    logic             w_err_nxt;
    logic             w_rise;
    logic             w_en;
    logic             w_clr;
    logic             w_tick;
    logic             w_pwm;

    assign w_rise = r_req_s2 && !r_req_d;
    assign w_en   = (r_state == STEP) || (r_state == DC_RUN);
    assign w_clr  = (w_next_state != r_state);

    dispense_tick_gen #(
        .STEP_DIV   (STEP_DIV),
        .PWM_PERIOD (PWM_PERIOD),
        .PWM_DUTY   (PWM_DUTY)
    ) u_tick_gen (
        .clk      (clk),
        .rstn     (rstn),
        .i_en     (w_en),
        .i_clr    (w_clr),
        .o_tick_c (w_tick),
        .o_pwm_c  (w_pwm)
    );

    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_step_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_cnt_nxt = '0;
                    case (r_amt_s2)
                        AMT_SMALL:   begin w_target_nxt = CNT_W'(STEPS_SMALL); w_next_state = STEP; end
                        AMT_MED:     begin w_target_nxt = CNT_W'(STEPS_MED);   w_next_state = STEP; end
                        AMT_LARGE:   begin w_target_nxt = CNT_W'(STEPS_LARGE); w_next_state = STEP; end
                        AMT_INVALID: w_next_state = ERROR;
                        default:     w_next_state = ERROR;
                    endcase
                end
            end
            STEP: begin
                w_step_nxt = r_out.step;
                if (w_tick) begin
                    w_step_nxt = !r_out.step;
                    // A completed step is counted on the falling half of the pulse.
                    if (r_out.step) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt + CNT_W'(1) == r_target) begin
                            w_cnt_nxt    = '0;
                            w_next_state = DC_RUN;
                        end
                    end
                end
`ifdef DISPENSE_ABORT_EN
                if (!r_req_s2) w_next_state = IDLE;
`endif
            end
            DC_RUN: begin
                if (w_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt + CNT_W'(1) == CNT_W'(DC_HOLD)) begin
                        w_cnt_nxt    = '0;
                        w_next_state = DONE;
                    end
                end
`ifdef DISPENSE_ABORT_EN
                if (!r_req_s2) w_next_state = IDLE;
`endif
            end
            DONE, ERROR: begin
                if (!r_req_s2) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase

        w_out_nxt = MOTOR_BRAKE;
        if (w_next_state == STEP) begin
            w_out_nxt.step = w_step_nxt;
        end else if (w_next_state == DC_RUN) begin
            w_out_nxt.dc_in1 = 1'b1;
            w_out_nxt.dc_in2 = 1'b0;
            w_out_nxt.dc_pwm = (r_state == DC_RUN) ? w_pwm : (PWM_DUTY != 0);
        end
        w_busy_nxt = (w_next_state == STEP) || (w_next_state == DC_RUN);
        w_ack_nxt  = (w_next_state == DONE) || (w_next_state == ERROR);
        w_err_nxt  = (w_next_state == ERROR);
    end

    // Sync flops reset high so a req already asserted at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req_s1 <= 1'b1;
            r_req_s2 <= 1'b1;
            r_req_d  <= 1'b1;
            r_amt_s1 <= '0;
            r_amt_s2 <= '0;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_target <= '0;
            r_out    <= MOTOR_BRAKE;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_req_s1 <= req_i;
            r_req_s2 <= r_req_s1;
            r_req_d  <= r_req_s2;
            r_amt_s1 <= amount_i;
            r_amt_s2 <= r_amt_s1;
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_out    <= w_out_nxt;
            r_ack    <= w_ack_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign step_o   = r_out.step;
    assign dir_o    = r_out.dir;
    assign dc_in1_o = r_out.dc_in1;
    assign dc_in2_o = r_out.dc_in2;
    assign dc_pwm_o = r_out.dc_pwm;
    assign ack_o    = r_ack;
    assign busy_o   = r_busy;
    assign err_o    = r_err;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Scoreboard bench for dispense_sequencer: randomized transactions against a cycle-timeline model.
module tb_dispense_sequencer;

    localparam int DIV     = 4;
    localparam int PER     = 10;
    localparam int DUTY    = 4;
    localparam int S_SMALL = 3;
    localparam int S_MED   = 5;
    localparam int S_LARGE = 7;
    localparam int HOLD    = 2;
    // {step, dir, in1, in2, pwm, ack, busy, err}
    localparam logic [7:0] IDLE_VEC = 8'b0001_0000;

    typedef struct {
        int target;
        bit err;
        int f;          // req drop: f cycles after the first busy/ack sample
        int start_cyc;  // cycle count at which the DUT must start presenting
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       req_i;
    logic [1:0] amount_i;
    logic       step_o, dir_o, dc_in1_o, dc_in2_o, dc_pwm_o, ack_o, busy_o, err_o;
    logic [7:0] vec;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   mon_active = 0;
    int   mon_k = 0;

    dispense_sequencer #(
        .STEP_DIV    (DIV),
        .PWM_PERIOD  (PER),
        .PWM_DUTY    (DUTY),
        .STEPS_SMALL (S_SMALL),
        .STEPS_MED   (S_MED),
        .STEPS_LARGE (S_LARGE),
        .DC_HOLD     (HOLD)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_i    (req_i),
        .amount_i (amount_i),
        .step_o   (step_o),
        .dir_o    (dir_o),
        .dc_in1_o (dc_in1_o),
        .dc_in2_o (dc_in2_o),
        .dc_pwm_o (dc_pwm_o),
        .ack_o    (ack_o),
        .busy_o   (busy_o),
        .err_o    (err_o)
    );

    assign vec = {step_o, dir_o, dc_in1_o, dc_in2_o, dc_pwm_o, ack_o, busy_o, err_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int target_of(input logic [1:0] a);
        case (a)
            2'b00:   return S_SMALL;
            2'b01:   return S_MED;
            2'b10:   return S_LARGE;
            default: return 0;
        endcase
    endfunction

    // Sample index at which the transaction is over and outputs are idle again.
    function automatic int model_end(input exp_t e);
        int t_end;
        if (e.err) return e.f + 3;
        t_end = 2 * DIV * e.target + HOLD * DIV;
`ifdef DISPENSE_ABORT_EN
        if (e.f + 3 <= t_end) return e.f + 3;
`endif
        return (t_end + 1 > e.f + 3) ? t_end + 1 : e.f + 3;
    endfunction

    function automatic logic [7:0] model_vec(input exp_t e, input int k);
        int t_step;
        int t_end;
        logic s;
        logic p;
        t_step = 2 * DIV * e.target;
        t_end  = t_step + HOLD * DIV;
        if (k >= model_end(e)) return IDLE_VEC;
        if (e.err) return 8'b0001_0101;
        if (k < t_step) begin
            s = ((k / DIV) % 2) == 1;
            return {s, 7'b001_0010};
        end
        if (k < t_end) begin
            p = ((k - t_step) % PER) < DUTY;
            return {4'b0010, p, 3'b010};
        end
        return 8'b0001_0100;
    endfunction

    // Monitor: pop an expectation when the DUT starts a transaction, then compare every cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            mon_active = 0;
            chk("reset_outputs", 32'(vec), 32'(IDLE_VEC));
        end else begin
            if (!mon_active && (busy_o || ack_o) && exp_q.size() != 0) begin
                cur        = exp_q.pop_front();
                mon_active = 1;
                mon_k      = 0;
                chk("start_cycle", 32'(cyc), 32'(cur.start_cyc));
            end
            if (mon_active) begin
                chk($sformatf("txn_k%0d_tgt%0d_err%0d_f%0d", mon_k, cur.target, cur.err, cur.f),
                    32'(vec), 32'(model_vec(cur, mon_k)));
                if (mon_k >= model_end(cur)) mon_active = 0;
                mon_k++;
            end else begin
                chk("idle_outputs", 32'(vec), 32'(IDLE_VEC));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: got busy=%0b ack=%0b, required completion within 400 cycles",
                     busy_o, ack_o);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_txn(input logic [1:0] amt, input int f, input bit chg);
        exp_t e;
        @(posedge clk); #1 amount_i = amt;
        @(posedge clk); #1 req_i = 1'b1;
        e.target    = target_of(amt);
        e.err       = (amt == 2'b11);
        e.f         = f;
        e.start_cyc = cyc + 3;
        exp_q.push_back(e);
        repeat (3) @(posedge clk);
        #1 if (chg) amount_i = 2'b10;
        repeat (f) @(posedge clk);
        #1 req_i = 1'b0;
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [1:0] amt;
        int t_end;
        int f;

        rstn     = 1'b0;
        req_i    = 1'b0;
        amount_i = 2'b00;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", 32'(vec), 32'(IDLE_VEC));
        rstn = 1'b1;
        repeat (4) @(posedge clk);

        // Small dispense with req held well past the DC run.
        run_txn(2'b00, 40, 1'b0);
        // Invalid code.
        run_txn(2'b11, 6, 1'b0);
        // Amount changed after acceptance.
        run_txn(2'b00, 40, 1'b1);
        // Req dropped during the 2nd step pulse.
        run_txn(2'b00, 12, 1'b0);

        // Reset during the 2nd step pulse, req still high.
        @(posedge clk); #1 amount_i = 2'b00;
        @(posedge clk); #1 req_i = 1'b1;
        e.target = S_SMALL; e.err = 0; e.f = 100000; e.start_cyc = cyc + 3;
        exp_q.push_back(e);
        repeat (3 + 3 * DIV + 1) @(posedge clk);
        #1 chk("pre_reset_step", 32'(step_o), 32'(1));
        rstn = 1'b0;
        #1 chk("reset_async", 32'(vec), 32'(IDLE_VEC));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (30) @(posedge clk);
        #1 req_i = 1'b0;
        repeat (5) @(posedge clk);

        // Req already high when reset is released.
        #1 rstn = 1'b0;
        req_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (30) @(posedge clk);
        #1 req_i = 1'b0;
        repeat (5) @(posedge clk);

        // Fresh edge after the reset cases.
        run_txn(2'b01, 60, 1'b0);

        for (int i = 0; i < 20; i++) begin
            amt   = 2'($urandom_range(0, 3));
            t_end = 2 * DIV * target_of(amt) + HOLD * DIV;
            f     = (amt == 2'b11) ? $urandom_range(0, 8) : $urandom_range(0, t_end + 6);
            run_txn(amt, f, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
